spi_reg_peripheral: RTL
=======================

// Module: spi_reg_peripheral
// PURPOSE
//   SPI (mode 0) target that sits upstream of the PWM output stage in the onboarding top.
//   Decodes 16-bit host frames into a 5-entry control register file.
//   Drives the output-enable, PWM-enable and duty-cycle buses consumed by the PWM block.
//   SPI pins are asynchronous to clk; all logic runs in the clk domain (oversampled).
// PARAMETERS
//   SYNC_STAGES  2   flip-flop depth of the sclk/copi/ncs synchronisers (>=2)
//   MAX_ADDR     4   highest writable address; frames to higher addresses are dropped
// PORTS
//   clk              in   1  system clock (>= 8x sclk)
//   rst_n            in   1  asynchronous active-low reset
//   sclk             in   1  SPI clock from host, idle low
//   copi             in   1  SPI data host->target, sampled on sclk rising edge
//   ncs              in   1  SPI chip select, active low
//   cipo             out  1  SPI data target->host (see CONFIGURATION)
//   en_reg_out_7_0   out  8  addr 0x00: output enables, bits 7:0
//   en_reg_out_15_8  out  8  addr 0x01: output enables, bits 15:8
//   en_reg_pwm_7_0   out  8  addr 0x02: PWM mode select, bits 7:0
//   en_reg_pwm_15_8  out  8  addr 0x03: PWM mode select, bits 15:8
//   pwm_duty_cycle   out  8  addr 0x04: duty cycle (0x00=0%, 0xFF=100%)
// BEHAVIOUR
//   Reset: all five registers = 0x00, cipo = 0, state = IDLE, bit counter = 0, shift reg = 0.
//   Synchronisation: sclk, copi and ncs each pass SYNC_STAGES flops.
//   - Edge detection compares the last synchronised stage with one extra delayed flop.
//   Frame format (MSB first, 16 bits): [15] R/W (1=write), [14:8] address, [7:0] data.
//   FSM:
//   - IDLE: synced ncs falling edge -> SHIFT; clear bit counter and shift reg.
//   - SHIFT: each synced sclk rising edge shifts copi in; counter saturates at 17.
//   - SHIFT: synced ncs rising edge -> COMMIT.
//   - COMMIT: one clk; if counter==16 and R/W==1 and addr<=MAX_ADDR, write data to
//     the addressed register; otherwise discard. Always -> IDLE.
//   Latency: register output changes exactly SYNC_STAGES+2 clk edges after the ncs pin rises.
//   Boundaries:
//   - Short (<16) or long (>16) frames: discarded; registers are unchanged.
//   - Addr 0x05..0x7F: discarded.
//   - sclk edges while ncs is high: ignored.
//   - ncs falling edge in COMMIT: COMMIT completes, then IDLE; the next frame starts
//     on the following ncs falling edge. Hosts guarantee >= 4 clk of ncs high between frames.
//   - Back-to-back writes to the same addr: the last completed frame wins.
//   - rst_n low mid-frame: immediate clear to reset values; the partial frame is lost.
// CONFIGURATION
//   SPI_READBACK_EN defined:
//   - R/W==0 frames are reads. After the 8th sclk rising edge, the addressed register
//     (0x00 for addr>MAX_ADDR) loads an output shift reg.
//   - cipo updates on each synced sclk falling edge (bits 7..0, MSB first).
//   - Read frames never modify registers.
//   - cipo returns to 0 on the ncs rising edge.
//   SPI_READBACK_EN undefined:
//   - R/W==0 frames are discarded; cipo is tied 0; no output shift reg is synthesised.
// TESTING
//   1 Reset: rst_n=0 for 5 clk -> all five registers 0x00, cipo=0.
//   2 Write 0x80 0xF0 (addr0), then 0x84 0x80 (addr4) -> en_reg_out_7_0=0xF0,
//     pwm_duty_cycle=0x80; others stay 0x00.
//   3 Write 0x85 0xAA (addr5), then 15-bit and 17-bit frames to addr1 -> no register changes.
//   4 Send 0x02 0x55 (R/W=0) without SPI_READBACK_EN -> registers unchanged, cipo stays 0.
//   5 With SPI_READBACK_EN: write 0x83 0x3C, then read 0x03 0x00 -> cipo returns 0x3C
//     (MSB first); en_reg_pwm_15_8 stays 0x3C.
//   6 Write to addr2 with rst_n pulsed low after bit 9 -> en_reg_pwm_7_0=0x00;
//     the next full write 0x82 0x11 gives 0x11.

Source files
------------

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 target driving a 5-entry PWM control register file (optional SPI_READBACK_EN)
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Highest address that both passes the MAX_ADDR filter and exists in the file.
  localparam int         LAST_I = (MAX_ADDR < 4) ? MAX_ADDR : 4;
  localparam logic [6:0] LAST   = 7'(LAST_I);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   ncs_dly_q, ncs_dly_d;
  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [15:0]            shift_q, shift_d;
  logic [7:0]             regs_q [5];
  logic [7:0]             regs_d [5];

  logic        sclk_s, copi_s, ncs_s;
  logic        sclk_rise, ncs_rise, ncs_fall;
  logic [15:0] nxt_shift;
  logic [6:0]  wr_addr;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;
  assign nxt_shift = {shift_q[14:0], copi_s};
  assign wr_addr   = shift_q[14:8];

  // Synchroniser chains plus the extra delay flop used for edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    sclk_dly_d  = sclk_s;
    ncs_dly_d   = ncs_s;
  end

  // Frame FSM: capture bits between chip-select edges, commit one clk after release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d   = 5'd0;
          shift_d = 16'h0000;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          shift_d = nxt_shift;
          cnt_d   = (cnt_q == 5'd17) ? 5'd17 : cnt_q + 5'd1;
        end
      end
      COMMIT: begin
        if (cnt_q == 5'd16 && shift_q[15] && wr_addr <= LAST) begin
          regs_d[wr_addr[2:0]] = shift_q[7:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, synchroniser and register-file flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= 16'h0000;
      for (int i = 0; i < 5; i++) regs_q[i] <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ncs_dly_q   <= ncs_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] out_q, out_d;
  logic       cipo_q, cipo_d;
  logic [7:0] rd_data;

  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign rd_data   = (nxt_shift[6:0] <= LAST) ? regs_q[nxt_shift[2:0]] : 8'h00;

  // Read path: load on the 8th rising edge of a read frame, shift out on falling edges.
  always_comb begin
    out_d  = out_q;
    cipo_d = cipo_q;
    if (state_q != SHIFT || ncs_rise) begin
      out_d  = 8'h00;
      cipo_d = 1'b0;
    end else if (sclk_rise && cnt_q == 5'd7 && !nxt_shift[7]) begin
      out_d = rd_data;
    end else if (sclk_fall) begin
      cipo_d = out_q[7];
      out_d  = {out_q[6:0], 1'b0};
    end
  end

  // Read-path flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= 8'h00;
      cipo_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cipo_q <= cipo_d;
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule
